// File: rtl/weight_fetch.sv
// -----------------------------------------------------------------------------
// weight_fetch
//
// Streams a job of weight rows from a row-addressed weight memory into the
// weight FIFO. A job covers num_tiles_i * ROWS_PER_TILE consecutive rows
// starting at base_addr_i; the address wraps modulo 2^ADDR_W. Returned rows
// land in a 2-entry skid FIFO. Reads are only issued when the skid FIFO is
// guaranteed to have room for the returning row, so backpressure from the FIFO
// never drops or duplicates a row.
//
// Optional feature: define WEIGHT_FETCH_STALL_CNT_EN to build the saturating
// backpressure stall counter. Without it stall_cnt_o is tied to zero.
//
// Ports
//   clk_i           in   sole clock, rising edge
//   rst_i           in   synchronous active-high reset
//   start_i         in   one-cycle job launch, accepted only in IDLE
//   base_addr_i     in   first row address, captured on accepted start
//   num_tiles_i     in   tile count (0 legal), captured on accepted start
//   mem_rd_en_o     out  weight-memory read strobe
//   mem_addr_o      out  weight-memory row address
//   mem_rdata_i     in   row data, valid one cycle after mem_rd_en_o
//   write_en_o      out  weight FIFO write enable (FETCH and DRAIN)
//   request_data_i  in   FIFO accept (write_en and not full)
//   sending_data_o  out  data_o holds a valid row
//   data_o          out  row presented to the FIFO (skid FIFO head)
//   busy_o          out  state is not IDLE
//   done_o          out  one-cycle job-complete pulse
//   stall_cnt_o     out  backpressure stall counter
// -----------------------------------------------------------------------------
module weight_fetch #(
  parameter int ADDR_W        = 16,
  parameter int ROWS_PER_TILE = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [ADDR_W-1:0]             base_addr_i,
  input  logic [7:0]                    num_tiles_i,
  output logic                          mem_rd_en_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  input  logic [ROWS_PER_TILE-1:0][7:0] mem_rdata_i,
  output logic                          write_en_o,
  input  logic                          request_data_i,
  output logic                          sending_data_o,
  output logic [ROWS_PER_TILE-1:0][7:0] data_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [15:0]                   stall_cnt_o
);

  typedef logic [ROWS_PER_TILE-1:0][7:0] row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [12:0]       rows_q, rows_d;       // rows still to be read
  logic [ADDR_W-1:0] addr_q, addr_d;       // next row address to read
  logic              inflight_q;           // read issued last cycle; data on mem_rdata_i now
  logic [1:0]        count_q, count_d;     // skid FIFO occupancy (0..2)
  row_t              ent0_q, ent0_d;       // skid FIFO head
  row_t              ent1_q, ent1_d;       // skid FIFO second entry

  logic start_acc;
  logic push;
  logic pop;
  logic credit_ok;
  logic rd_en;

  assign start_acc = (state_q == IDLE) && start_i;
  assign push      = inflight_q;
  assign pop       = (count_q != 2'd0) && request_data_i;

  // Room check counts the row already in flight and credits this cycle's pop,
  // so a newly issued read always finds a free slot when its data returns.
  assign credit_ok = (({1'b0, count_q} + {2'b00, inflight_q}) - {2'b00, pop}) < 3'd2;
  assign rd_en     = (state_q == FETCH) && (rows_q != 13'd0) && credit_ok;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d = FETCH;
          rows_d  = 13'(num_tiles_i) * 13'(ROWS_PER_TILE);
          addr_d  = base_addr_i;
        end
      end
      FETCH: begin
        if (rd_en) begin
          rows_d = rows_q - 13'd1;
          addr_d = addr_q + ADDR_W'(1);
          if (rows_q == 13'd1) begin
            state_d = DRAIN;
          end
        end else if (rows_q == 13'd0) begin
          // Zero-tile job: nothing to read.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && (count_q == 2'd0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Skid FIFO (entry 0 is always the head)
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    case ({push, pop})
      2'b11: begin
        // Occupancy unchanged; the new row goes behind whatever remains.
        if (count_q == 2'd1) begin
          ent0_d = mem_rdata_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = mem_rdata_i;
        end
      end
      2'b10: begin
        if (count_q == 2'd0) begin
          ent0_d = mem_rdata_i;
        end else begin
          ent1_d = mem_rdata_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rows_q     <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;   // any returning row is discarded
      count_q    <= '0;
      ent0_q     <= '0;
      ent1_q     <= '0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      addr_q     <= addr_d;
      inflight_q <= rd_en;
      count_q    <= count_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_rd_en_o    = rd_en;
  assign mem_addr_o     = addr_q;
  assign write_en_o     = (state_q == FETCH) || (state_q == DRAIN);
  assign sending_data_o = (count_q != 2'd0);
  assign data_o         = ent0_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);

`ifdef WEIGHT_FETCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (sending_data_o && !request_data_i && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/weight_fetch.md
WEIGHT_FETCH -- requirements
Module: weight_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, weight-memory row-address width.
REQ-002 SHALL have parameter ROWS_PER_TILE, default 32, rows per weight tile, fixed equal to the array dimension.
REQ-003 SHALL have port clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start_i  input  1  one-cycle job launch, sampled only in IDLE.
REQ-006 SHALL have port base_addr_i  input  ADDR_W  first row address, captured on accepted start.
REQ-007 SHALL have port num_tiles_i  input  8  tile count, captured on accepted start; 0 is legal.
REQ-008 SHALL have port mem_rd_en_o  output  1  weight-memory read strobe.
REQ-009 SHALL have port mem_addr_o  output  ADDR_W  weight-memory row address.
REQ-010 SHALL have port mem_rdata_i  input  32x8  row data, valid exactly one cycle after mem_rd_en_o.
REQ-011 SHALL have port write_en_o  output  1  drives the weight FIFO write enable; high while a job is active.
REQ-012 SHALL have port request_data_i  input  1  FIFO accept signal (write_en and not full).
REQ-013 SHALL have port sending_data_o  output  1  data_o holds a valid row.
REQ-014 SHALL have port data_o  output  32x8  row presented to the FIFO.
REQ-015 SHALL have port busy_o  output  1  state is not IDLE.
REQ-016 SHALL have port done_o  output  1  one-cycle job-complete pulse.
REQ-017 SHALL have port stall_cnt_o  output  16  backpressure stall counter.

Function
REQ-018 SHALL implement FSM IDLE -> FETCH on start_i; FETCH -> DRAIN when the last row read is issued; DRAIN -> DONE when no read is in flight and the skid buffer is empty; DONE -> IDLE unconditionally.
REQ-019 SHALL hold total rows = num_tiles_i*ROWS_PER_TILE in a 13-bit down-counter.
REQ-020 SHALL issue row reads at base_addr, base_addr+1, ... in order, with the address wrapping modulo 2^ADDR_W.
REQ-021 SHALL capture mem_rdata_i into a 2-entry skid FIFO on the cycle after each issued read.
REQ-022 SHALL issue a read only when occupancy + in-flight - pop < 2, so that no returned row is ever dropped.
REQ-023 SHALL drive sending_data_o = skid FIFO non-empty and data_o = skid head.
REQ-024 SHALL count a transfer only in a cycle where sending_data_o and request_data_i are both high; that transfer pops the head.
REQ-025 SHALL hold data_o stable while sending_data_o=1 and request_data_i=0.
REQ-026 SHALL sustain one row per cycle while request_data_i stays high.
REQ-027 SHALL give the following latency, with request_data_i held high, for an accepted start in cycle 0: mem_rd_en_o in cycle 1; sending_data_o in cycle 3.
REQ-028 SHALL assert write_en_o in FETCH and DRAIN only.
REQ-029 SHALL assert done_o for exactly one cycle, in DONE.
REQ-030 SHALL, for num_tiles_i=0, go IDLE -> FETCH -> DRAIN -> DONE with no reads and no sending_data_o.
REQ-031 SHALL ignore start_i while busy_o=1.
REQ-032 SHALL, on simultaneous push and pop, keep occupancy unchanged and preserve row order.

Reset
REQ-033 SHALL, on rst_i, force state IDLE and all outputs to 0: mem_rd_en_o, mem_addr_o, write_en_o, sending_data_o, data_o, busy_o, done_o and stall_cnt_o.
REQ-034 SHALL, on rst_i mid-job, clear the row counter and skid FIFO, discard any in-flight read data, and suppress done_o.

Configuration
REQ-035 SHALL use macro WEIGHT_FETCH_STALL_CNT_EN to control the stall counter.
REQ-036 SHALL, with WEIGHT_FETCH_STALL_CNT_EN defined: clear stall_cnt_o on accepted start; increment it each cycle with sending_data_o=1 and request_data_i=0; saturate at 16'hFFFF.
REQ-037 SHALL, without WEIGHT_FETCH_STALL_CNT_EN, tie stall_cnt_o to 0 and synthesize no counter logic.

Verification
REQ-038 SHALL cover: base=0x0010, tiles=1, request_data_i constantly 1 -> 32 reads at 0x0010..0x002F in consecutive cycles, 32 transfers in order, done_o pulses once, busy_o then drops.
REQ-039 SHALL cover: tiles=2, request_data_i low for 5 cycles mid-job -> at most 2 rows buffered, no row lost or duplicated, 64 rows total, stall_cnt_o=5 with the macro and 0 without.
REQ-040 SHALL cover: base=0xFFF0, tiles=1 -> addresses 0xFFF0..0xFFFF followed by 0x0000..0x000F.
REQ-041 SHALL cover: tiles=0 -> no mem_rd_en_o, no sending_data_o, done_o 3 cycles after start.
REQ-042 SHALL cover: start_i pulsed during a job -> ignored, and the row count stays as the original job's.
REQ-043 SHALL cover: rst_i at row 10 of 32, then new start with tiles=1 -> the new job delivers exactly 32 rows starting at the new base, and no stale data appears.
